// File: rtl/alu_operand_loader.sv
// Collects opcode/A/B bytes from the 8-bit pin bus and presents full-width operands to the ALU.
// Holds the operands through the settle window, then captures the result into a chainable accumulator.
module alu_operand_loader #(
  parameter int ALU_LAT = 0,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] din,
  input  logic       load,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  output logic       issue,
  output logic       busy,
  output logic [7:0] acc,
  output logic       acc_cout,
  output logic       res_valid,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, GET_A, GET_B, ISSUE} state_t;

  localparam logic [3:0] LAT     = 4'(ALU_LAT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [7:0] idle_cnt;
  logic       collecting;
  logic       timeout;
  logic       last_issue;

  assign collecting = (state == GET_A) || (state == GET_B);
  assign timeout    = collecting && ena && !load && (idle_cnt == TO_LAST);
  assign last_issue = (state == ISSUE) && (wait_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        IDLE:    if (load) state_nxt = din[0] ? GET_B : GET_A;
        GET_A:   if (load) state_nxt = GET_B;
                 else if (timeout) state_nxt = IDLE;
        GET_B:   if (load) state_nxt = ISSUE;
                 else if (timeout) state_nxt = IDLE;
        ISSUE:   if (last_issue) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The settle counter starts at LAT, so it still equals LAT only in the first ISSUE cycle.
  always_comb begin
    issue = (state == ISSUE) && (wait_cnt == LAT);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_sel   <= 3'd0;
      acc       <= 8'd0;
      acc_cout  <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= 4'd0;
      idle_cnt  <= 8'd0;
    end else if (ena) begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= 8'd0;
          if (load) begin
            alu_sel <= din[7:5];
            if (din[0]) alu_a <= acc;
          end
        end
        GET_A, GET_B: begin
          if (load || timeout) idle_cnt <= 8'd0;
          else                 idle_cnt <= idle_cnt + 8'd1;
          if (timeout) err <= 1'b1;
          if (load && state == GET_A) alu_a <= din;
          if (load && state == GET_B) begin
            alu_b    <= din;
            wait_cnt <= LAT;
          end
        end
        ISSUE: begin
          if (load) err <= 1'b1;
          if (last_issue) begin
            acc       <= alu_result;
            acc_cout  <= alu_cout;
            res_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed scenarios then random traffic, every cycle compared against a byte-collecting reference model.
module tb_alu_operand_loader;
  localparam int LAT = 3;
  localparam int TO  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] alu_result = 8'd0;
  logic       alu_cout = 1'b0;
  logic [7:0] alu_a, alu_b, acc;
  logic [2:0] alu_sel;
  logic       issue, busy, acc_cout, res_valid, err;

  alu_operand_loader #(.ALU_LAT(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .load(load),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .issue(issue), .busy(busy),
    .acc(acc), .acc_cout(acc_cout), .res_valid(res_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes still owed by the current command and ISSUE cycles remaining.
  logic [7:0] m_a, m_b, m_acc;
  logic [2:0] m_sel;
  bit         m_cout, m_rv, m_err;
  int         m_need, m_left, m_idle;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_acc = 0; m_sel = 0;
    m_cout = 0; m_rv = 0; m_err = 0;
    m_need = 0; m_left = 0; m_idle = 0;
  endtask

  task automatic model_edge();
    if (!ena) return;
    m_rv = 0;
    if (m_left > 0) begin
      if (load) m_err = 1;
      m_left--;
      if (m_left == 0) begin
        m_acc = alu_result; m_cout = alu_cout; m_rv = 1;
      end
    end else if (m_need == 0) begin
      m_idle = 0;
      if (load) begin
        m_sel = din[7:5];
        if (din[0]) begin m_a = m_acc; m_need = 1; end
        else m_need = 2;
      end
    end else if (load) begin
      m_idle = 0;
      if (m_need == 2) begin m_a = din; m_need = 1; end
      else begin m_b = din; m_need = 0; m_left = LAT + 1; end
    end else begin
      m_idle++;
      if (m_idle == TO) begin m_need = 0; m_idle = 0; m_err = 1; end
    end
  endtask

  task automatic check_all();
    check("alu_a", 16'(alu_a), 16'(m_a));
    check("alu_b", 16'(alu_b), 16'(m_b));
    check("alu_sel", 16'(alu_sel), 16'(m_sel));
    check("issue", 16'(issue), 16'(m_left == LAT + 1));
    check("busy", 16'(busy), 16'(m_need != 0 || m_left != 0));
    check("acc", 16'(acc), 16'(m_acc));
    check("acc_cout", 16'(acc_cout), 16'(m_cout));
    check("res_valid", 16'(res_valid), 16'(m_rv));
    check("err", 16'(err), 16'(m_err));
  endtask

  task automatic cyc(input bit e, input bit l, input logic [7:0] d, input logic [7:0] r, input bit c);
    @(negedge clk);
    ena = e; load = l; din = d; alu_result = r; alu_cout = c;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    ena = 0; load = 0;
    #1 rst = 1;
    #1 model_reset();
    check_all();
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_acc", 16'(acc), 16'h0);
    #2 rst = 0;
  endtask

  initial begin
    model_reset();
    #1 check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Basic three-byte command
    cyc(1, 1, 8'h00, 8'h46, 0);
    cyc(1, 1, 8'h12, 8'h46, 0);
    cyc(1, 1, 8'h34, 8'h46, 0);
    check("basic_issue", 16'(issue), 16'h1);
    check("basic_a", 16'(alu_a), 16'h12);
    check("basic_b", 16'(alu_b), 16'h34);
    repeat (LAT) cyc(1, 0, 8'h00, 8'h46, 0);
    check("lat_no_rv_yet", 16'(res_valid), 16'h0);
    check("lat_busy", 16'(busy), 16'h1);
    cyc(1, 0, 8'h00, 8'h46, 0);
    check("basic_acc", 16'(acc), 16'h46);
    check("basic_rv", 16'(res_valid), 16'h1);
    check("basic_idle", 16'(busy), 16'h0);

    // Chained command accepted in the res_valid cycle
    cyc(1, 1, 8'h21, 8'h41, 1);
    cyc(1, 1, 8'h05, 8'h41, 1);
    check("chain_sel", 16'(alu_sel), 16'h1);
    check("chain_a", 16'(alu_a), 16'h46);
    check("chain_b", 16'(alu_b), 16'h05);
    repeat (LAT + 1) cyc(1, 0, 8'h00, 8'h41, 1);
    check("chain_acc", 16'(acc), 16'h41);
    check("chain_cout", 16'(acc_cout), 16'h1);

    // Timeout in GET_A, then a normal command
    cyc(1, 1, 8'h40, 8'h00, 0);
    repeat (TO - 1) cyc(1, 0, 8'h00, 8'h00, 0);
    check("to_still_busy", 16'(busy), 16'h1);
    cyc(1, 0, 8'h00, 8'h00, 0);
    check("to_idle", 16'(busy), 16'h0);
    check("to_err", 16'(err), 16'h1);
    check("to_acc_kept", 16'(acc), 16'h41);
    cyc(1, 1, 8'h60, 8'h99, 0);
    cyc(1, 1, 8'h11, 8'h99, 0);
    cyc(1, 1, 8'h22, 8'h99, 0);
    repeat (LAT + 1) cyc(1, 0, 8'h00, 8'h99, 0);
    check("after_to_acc", 16'(acc), 16'h99);
    check("after_to_sel", 16'(alu_sel), 16'h3);

    // Async reset in GET_B, then a command with an overrun byte in ISSUE
    cyc(1, 1, 8'h00, 8'h00, 0);
    cyc(1, 1, 8'h55, 8'h00, 0);
    async_reset();
    cyc(1, 1, 8'h40, 8'h0F, 0);
    cyc(1, 1, 8'h07, 8'h0F, 0);
    cyc(1, 1, 8'h08, 8'h0F, 0);
    cyc(1, 1, 8'hAA, 8'h0F, 0);
    check("ovr_err", 16'(err), 16'h1);
    check("ovr_b_kept", 16'(alu_b), 16'h08);
    repeat (LAT) cyc(1, 0, 8'h00, 8'h0F, 0);
    check("ovr_acc", 16'(acc), 16'h0F);
    check("ovr_rv", 16'(res_valid), 16'h1);

    // ena low mid-GET_B freezes the idle counter and ignores the strobe
    cyc(1, 1, 8'h00, 8'h00, 0);
    cyc(1, 1, 8'h10, 8'h00, 0);
    repeat (2) cyc(1, 0, 8'h00, 8'h00, 0);
    repeat (3) cyc(0, 1, 8'hEE, 8'h00, 0);
    check("ena_b_kept", 16'(alu_b), 16'h08);
    cyc(1, 0, 8'h00, 8'h00, 0);
    check("ena_frozen_busy", 16'(busy), 16'h1);
    cyc(1, 0, 8'h00, 8'h00, 0);
    check("ena_to_idle", 16'(busy), 16'h0);

    // Random traffic
    async_reset();
    repeat (600)
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
          8'($urandom), 8'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
